terrain_probe_sequencer: RTL

Time-multiplexes one single-port map BRAM (2-bit terrain per cell, row-major, WIDTH cells per row) across the five terrain probes the gameplay FSM needs each frame: center, x+, x-, y+, y-. It replaces five duplicated map BRAM instances with one instance plus this scheduler. On a start pulse it latches the ball position, issues five addresses back-to-back, absorbs the BRAM read latency, and presents all five terrain codes together with a one-cycle valid pulse.

---
 rtl/terrain_pkg.sv | 19 +
 rtl/probe_addr_gen.sv | 53 +++++
 rtl/terrain_probe_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/terrain_pkg.sv
// Shared terrain types for the probe sequencer, gameplay FSM and renderer.
// Terrain codes, probe slot order and the default edge-probe offset.
package terrain_pkg;

    typedef enum logic [1:0] {HOLE = 2'd0, WALL = 2'd1, GROUND = 2'd2, ROUGH = 2'd3} terrain_t;

    typedef enum logic [2:0] {P_CENTER, P_XPLUS, P_XMINUS, P_YPLUS, P_YMINUS} probe_idx_t;

    localparam int          NUM_PROBES           = 5;
    localparam logic [15:0] PROBE_OFFSET_DEFAULT = 16'h0080;

    // One in-flight BRAM read, carried alongside the read latency.
    typedef struct packed {
        logic       vld;
        probe_idx_t idx;
        logic       oob;
    } cap_slot_t;

endpackage

// File: rtl/probe_addr_gen.sv
// Combinational map address for one probe slot: applies the slot's offset to the
// latched 8.8 position, flags out-of-map / wrapped probes, and linearises row-major.
module probe_addr_gen
    import terrain_pkg::*;
#(
    parameter int          WIDTH        = 160,
    parameter int          HEIGHT       = 90,
    parameter logic [15:0] PROBE_OFFSET = PROBE_OFFSET_DEFAULT
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  probe_idx_t  slot_idx,
    output logic [15:0] addr,
    output logic        oob
);
    localparam logic [15:0] W16 = 16'(WIDTH);
    localparam logic [15:0] H16 = 16'(HEIGHT);

    logic [16:0] px, py, row;
    logic [15:0] cx, cy;

    always_comb begin
        px  = {1'b0, x};
        py  = {1'b0, y};
        oob = 1'b0;
        case (slot_idx)
            P_XPLUS: begin
                px  = {1'b0, x} + {1'b0, PROBE_OFFSET};
                oob = px[16];
            end
            P_XMINUS: begin
                oob = (x < PROBE_OFFSET);
                px  = {1'b0, x - PROBE_OFFSET};
            end
            P_YPLUS: begin
                py  = {1'b0, y} + {1'b0, PROBE_OFFSET};
                oob = py[16];
            end
            P_YMINUS: begin
                oob = (y < PROBE_OFFSET);
                py  = {1'b0, y - PROBE_OFFSET};
            end
            default: ;
        endcase
        cx = (px[15:0] >> 8);
        cy = (py[15:0] >> 8);
        if ((cx >= W16) || (cy >= H16))
            oob = 1'b1;
        row  = 17'(WIDTH) * {1'b0, cy};
        addr = oob ? 16'd0 : ((px[15:0] >> 8) + 16'(row));
    end

endmodule

// File: rtl/terrain_probe_sequencer.sv
// Shares one map BRAM across the five per-frame terrain probes: issues five reads
// back-to-back, absorbs the read latency and publishes all five codes at once.
module terrain_probe_sequencer
    import terrain_pkg::*;
#(
    parameter int          WIDTH        = 160,
    parameter int          HEIGHT       = 90,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] PROBE_OFFSET = PROBE_OFFSET_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        probe_start,
    input  logic [15:0] ball_x,
    input  logic [15:0] ball_y,
    output logic [15:0] bram_addr,
    output logic        bram_en,
    input  logic [1:0]  bram_dout,
    output logic [1:0]  terrain_center,
    output logic [1:0]  terrain_xplus,
    output logic [1:0]  terrain_xminus,
    output logic [1:0]  terrain_yplus,
    output logic [1:0]  terrain_yminus,
    output logic        probe_valid,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] x_q, y_q;
    logic [15:0] addr_g;
    logic        oob_g, issuing, last_drain;
    probe_idx_t  slot;
    cap_slot_t   cap_in;
    cap_slot_t   vld_pipe [READ_LATENCY:1];
    terrain_t    stage_q [NUM_PROBES];
    terrain_t    stage_d [NUM_PROBES];
    terrain_t    out_q [NUM_PROBES];

    assign issuing    = (state_q == S_ISSUE);
    assign last_drain = (state_q == S_DRAIN) && (cnt_q == 8'(READ_LATENCY - 1));
    assign slot       = probe_idx_t'(cnt_q[2:0]);

    probe_addr_gen #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .PROBE_OFFSET(PROBE_OFFSET)
    ) u_addr_gen (
        .x(x_q), .y(y_q), .slot_idx(slot), .addr(addr_g), .oob(oob_g)
    );

    // Out-of-bounds slots keep their cycle but never touch the BRAM.
    assign bram_en     = issuing & ~oob_g;
    assign bram_addr   = bram_en ? addr_g : 16'd0;
    assign busy        = (state_q != S_IDLE);
    assign probe_valid = (state_q == S_DONE);
    assign cap_in      = '{vld: issuing, idx: slot, oob: oob_g};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:
                if (probe_start) begin
                    state_d = S_ISSUE;
                    cnt_d   = 8'd0;
                end
            S_ISSUE:
                if (cnt_q == 8'(NUM_PROBES - 1)) begin
                    state_d = S_DRAIN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            S_DRAIN:
                if (last_drain) begin
                    state_d = S_DONE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == S_IDLE) && probe_start) begin
                x_q <= ball_x;
                y_q <= ball_y;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 1; i <= READ_LATENCY; i++) vld_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= cap_in;
            for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // stage_d already contains the final slot's capture, so outputs switch as a set.
    always_comb begin
        stage_d = stage_q;
        if (vld_pipe[READ_LATENCY].vld)
            stage_d[vld_pipe[READ_LATENCY].idx] =
                vld_pipe[READ_LATENCY].oob ? WALL : terrain_t'(bram_dout);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_PROBES; i++) begin
                stage_q[i] <= GROUND;
                out_q[i]   <= GROUND;
            end
        end else begin
            stage_q <= stage_d;
            if (last_drain) out_q <= stage_d;
        end
    end

    assign terrain_center = out_q[P_CENTER];
    assign terrain_xplus  = out_q[P_XPLUS];
    assign terrain_xminus = out_q[P_XMINUS];
    assign terrain_yplus  = out_q[P_YPLUS];
    assign terrain_yminus = out_q[P_YMINUS];

endmodule
